// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg
//   Shared types and constants for the UART receive frame controller.
//   FRAME_BITS  : data bits per frame (LSB first on the line)
//   rx_state_t  : frame sequencer states
//   rx_entry_t  : one buffered frame, framing-error flag above the data byte
package uart_rx_pkg;

    localparam int FRAME_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STOP
    } rx_state_t;

    typedef struct packed {
        logic                  ferr;
        logic [FRAME_BITS-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/uart_rx_frame_ctrl_sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with pointers one bit wider than the address so the
//   occupancy count never wraps and full/empty need no extra flag.
//   clk, rst_n      : clock, synchronous active-low reset
//   push, wr_data   : write request and data (accepted when not full, or
//                     when full but popping in the same cycle)
//   pop             : read request (ignored when empty)
//   rd_data         : head entry, zero while empty
//   full, empty     : occupancy flags
//   count           : number of occupied entries, 0..DEPTH
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok  = pop & ~empty;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign push_ok = push & (~full | pop_ok);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers define
    // which entries are live and rd_data is forced to zero while empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
//   Sequences receive frames from the bit detector strobes, assembles 8 data
//   bits LSB first, checks frame length and buffers completed frames with
//   their framing-error flag behind a valid/ready read port.
//   Optional feature macro: UART_RX_IDLE_TIMEOUT_EN (idle_timeout pulse when
//   data sits unread with no line activity for TIMEOUT_CYCLES cycles).
//   clk, rst_n        : clock, synchronous active-low reset
//   rx_en             : receive enable, low aborts any partial frame
//   active_rx         : detector inside a frame (falling edge aborts)
//   bit_ready, rx_bit : data bit strobe and value
//   done, framing_err : stop-bit strobe and its bad-stop qualifier
//   rd_data, rd_ferr  : head entry; rd_valid when non-empty
//   rd_ready          : host pop
//   fifo_count        : occupied entries
//   clr_status        : clears sticky overrun/ferr_seen/len_err
//   idle_timeout      : one-cycle pulse (0 when feature disabled)
module uart_rx_frame_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 160
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx_en,
    input  logic                   active_rx,
    input  logic                   bit_ready,
    input  logic                   rx_bit,
    input  logic                   done,
    input  logic                   framing_err,
    output logic [7:0]             rd_data,
    output logic                   rd_ferr,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [$clog2(DEPTH):0] fifo_count,
    input  logic                   clr_status,
    output logic                   overrun,
    output logic                   ferr_seen,
    output logic                   len_err,
    output logic                   idle_timeout
);

    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);
    localparam logic [3:0] CNT_FULL = 4'(FRAME_BITS);

    rx_state_t             state_q, state_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic                  active_rx_q;
    logic                  overrun_q, overrun_d;
    logic                  ferr_seen_q, ferr_seen_d;
    logic                  len_err_q, len_err_d;

    logic      active_fall;
    logic      push;
    logic      len_evt;
    logic      pop;
    logic      fifo_full;
    logic      fifo_empty;
    rx_entry_t wr_entry;
    rx_entry_t head;

    assign active_fall = active_rx_q & ~active_rx;

    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        push      = 1'b0;
        len_evt   = 1'b0;
        if (!rx_en) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (done) begin
                        len_evt   = 1'b1;
                        bit_cnt_d = '0;
                    end else if (bit_ready) begin
                        shreg_d   = {rx_bit, shreg_q[FRAME_BITS-1:1]};
                        bit_cnt_d = 4'd1;
                        state_d   = DATA;
                    end
                end
                DATA: begin
                    // Reaching here with done means fewer than 8 bits arrived.
                    if (done) begin
                        len_evt   = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end else if (bit_ready) begin
                        shreg_d   = {rx_bit, shreg_q[FRAME_BITS-1:1]};
                        bit_cnt_d = (bit_cnt_q == CNT_FULL) ? CNT_FULL : bit_cnt_q + 4'd1;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d = STOP;
                        end
                    end else if (active_fall) begin
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end
                end
                STOP: begin
                    if (done) begin
                        push      = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end else if (bit_ready) begin
                        len_evt   = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end else if (active_fall) begin
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end
                end
                default: begin
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                end
            endcase
        end
    end

    assign pop      = ~fifo_empty & rd_ready;
    assign wr_entry = '{ferr: framing_err, data: shreg_q};

    // Set wins over a same-cycle clear on every sticky bit.
    always_comb begin
        overrun_d   = (push & fifo_full & ~pop) | (overrun_q & ~clr_status);
        ferr_seen_d = (push & (~fifo_full | pop) & framing_err) | (ferr_seen_q & ~clr_status);
        len_err_d   = len_evt | (len_err_q & ~clr_status);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            active_rx_q <= 1'b0;
            overrun_q   <= 1'b0;
            ferr_seen_q <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            active_rx_q <= active_rx;
            overrun_q   <= overrun_d;
            ferr_seen_q <= ferr_seen_d;
            len_err_q   <= len_err_d;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(rx_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (wr_entry),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign rd_data   = head.data;
    assign rd_ferr   = head.ferr;
    assign rd_valid  = ~fifo_empty;
    assign overrun   = overrun_q;
    assign ferr_seen = ferr_seen_q;
    assign len_err   = len_err_q;

`ifdef UART_RX_IDLE_TIMEOUT_EN
    localparam int            TW      = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          idle_timeout_q, idle_timeout_d;

    // Counter parks at TO_LAST so the pulse fires once per idle stretch.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (bit_ready | done | active_rx | fifo_empty) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TO_LAST) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
        idle_timeout_d = (to_cnt_d == TO_LAST) && (to_cnt_q != TO_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt_q       <= '0;
            idle_timeout_q <= 1'b0;
        end else begin
            to_cnt_q       <= to_cnt_d;
            idle_timeout_q <= idle_timeout_d;
        end
    end

    assign idle_timeout = idle_timeout_q;
`else
    // Timeout disabled: the parameter is only kept for a uniform interface.
    logic timeout_param_unused;
    assign timeout_param_unused = (TIMEOUT_CYCLES < 2);
    assign idle_timeout         = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl
//   Directed bench: a table of single-frame vectors with hand-computed
//   results, then hand-written sequences for overrun, full-with-pop, status
//   clear priority, rx_en abort, active_rx abort and the idle timeout.
module tb_uart_rx_frame_ctrl;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 160;
`ifdef UART_RX_IDLE_TIMEOUT_EN
    localparam int EXP_PULSES = 1;
`else
    localparam int EXP_PULSES = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_en;
    logic       active_rx;
    logic       bit_ready;
    logic       rx_bit;
    logic       done;
    logic       framing_err;
    logic [7:0] rd_data;
    logic       rd_ferr;
    logic       rd_valid;
    logic       rd_ready;
    logic [2:0] fifo_count;
    logic       clr_status;
    logic       overrun;
    logic       ferr_seen;
    logic       len_err;
    logic       idle_timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pulse_cnt = 0;
    int last_pulse_cyc = -1;

    uart_rx_frame_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_en        (rx_en),
        .active_rx    (active_rx),
        .bit_ready    (bit_ready),
        .rx_bit       (rx_bit),
        .done         (done),
        .framing_err  (framing_err),
        .rd_data      (rd_data),
        .rd_ferr      (rd_ferr),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .fifo_count   (fifo_count),
        .clr_status   (clr_status),
        .overrun      (overrun),
        .ferr_seen    (ferr_seen),
        .len_err      (len_err),
        .idle_timeout (idle_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (idle_timeout) begin
            pulse_cnt      <= pulse_cnt + 1;
            last_pulse_cyc <= cyc;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] data;
        int         nbits;
        bit         send_done;
        bit         ferr;
        bit         exp_stored;
        logic [7:0] exp_data;
        bit         exp_ferr;
        bit         exp_len_err;
        bit         exp_ferr_seen;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs read then show
    // the state produced by that edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
    endtask

    // Sends nbits bits of data LSB first (bit i uses data[i mod 8]), then an
    // optional done strobe; pop_on_done raises rd_ready in the done cycle.
    task automatic send_frame(input logic [7:0] data, input int nbits, input bit send_done,
                              input bit ferr, input bit pop_on_done);
        active_rx = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            rx_bit    = data[i % 8];
            bit_ready = 1'b1;
            tick();
            bit_ready = 1'b0;
            tick();
        end
        if (send_done) begin
            done        = 1'b1;
            framing_err = ferr;
            rd_ready    = pop_on_done;
            tick();
            done        = 1'b0;
            framing_err = 1'b0;
            rd_ready    = 1'b0;
            active_rx   = 1'b0;
        end
    endtask

    task automatic pop_check(input string name, input logic [7:0] exp);
        check({name, "_valid"}, rd_valid, 1);
        check({name, "_data"}, rd_data, exp);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    initial begin
        int d0;
        int p0;

        vecs[0] = '{8'hA5, 8, 1, 0, 1, 8'hA5, 0, 0, 0};
        vecs[1] = '{8'h3C, 8, 1, 1, 1, 8'h3C, 1, 0, 1};
        vecs[2] = '{8'h55, 5, 1, 0, 0, 8'h00, 0, 1, 0};
        vecs[3] = '{8'hFF, 8, 1, 0, 1, 8'hFF, 0, 0, 0};
        vecs[4] = '{8'h00, 0, 1, 0, 0, 8'h00, 0, 1, 0};
        vecs[5] = '{8'hAA, 9, 0, 0, 0, 8'h00, 0, 1, 0};

        rst_n = 1'b0; rx_en = 1'b1; active_rx = 1'b0; bit_ready = 1'b0; rx_bit = 1'b0;
        done = 1'b0; framing_err = 1'b0; rd_ready = 1'b0; clr_status = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_ferr", rd_ferr, 0);
        check("rst_count", fifo_count, 0);
        check("rst_overrun", overrun, 0);
        check("rst_ferr_seen", ferr_seen, 0);
        check("rst_len_err", len_err, 0);
        check("rst_idle_timeout", idle_timeout, 0);

        // Table-driven single frames.
        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].data, vecs[v].nbits, vecs[v].send_done, vecs[v].ferr, 0);
            active_rx = 1'b0;
            check($sformatf("v%0d_valid", v), rd_valid, vecs[v].exp_stored);
            check($sformatf("v%0d_count", v), fifo_count, vecs[v].exp_stored ? 1 : 0);
            check($sformatf("v%0d_len_err", v), len_err, vecs[v].exp_len_err);
            check($sformatf("v%0d_ferr_seen", v), ferr_seen, vecs[v].exp_ferr_seen);
            if (vecs[v].exp_stored) begin
                check($sformatf("v%0d_ferr", v), rd_ferr, vecs[v].exp_ferr);
                pop_check($sformatf("v%0d", v), vecs[v].exp_data);
            end
            clr();
            check($sformatf("v%0d_clr_len_err", v), len_err, 0);
            check($sformatf("v%0d_clr_ferr_seen", v), ferr_seen, 0);
        end

        // rd_valid rises exactly one cycle after done.
        send_frame(8'hA5, 8, 0, 0, 0);
        check("pre_done_valid", rd_valid, 0);
        done = 1'b1;
        tick();
        done = 1'b0;
        active_rx = 1'b0;
        check("post_done_valid", rd_valid, 1);
        pop_check("post_done", 8'hA5);

        // Overrun: five frames into four entries with no reads.
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 8, 1, 0, 0);
        check("ovr_count4", fifo_count, 4);
        check("ovr_not_yet", overrun, 0);
        send_frame(8'h05, 8, 1, 0, 0);
        check("ovr_count_after", fifo_count, 4);
        check("ovr_set", overrun, 1);
        for (int i = 1; i <= 4; i++) pop_check($sformatf("ovr_pop%0d", i), 8'(i));
        check("ovr_drained", rd_valid, 0);
        clr();
        check("ovr_clr", overrun, 0);

        // Full FIFO with a pop in the same cycle as the fifth done.
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 8, 1, 0, 0);
        send_frame(8'h05, 8, 1, 0, 1);
        check("fullpop_count", fifo_count, 4);
        check("fullpop_overrun", overrun, 0);
        for (int i = 2; i <= 5; i++) pop_check($sformatf("fullpop_pop%0d", i), 8'(i));
        check("fullpop_drained", rd_valid, 0);

        // Pop on empty does nothing.
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("empty_pop_count", fifo_count, 0);

        // Push and pop together on an empty FIFO: entry is kept.
        send_frame(8'h77, 8, 1, 0, 1);
        check("emptypp_valid", rd_valid, 1);
        check("emptypp_count", fifo_count, 1);
        pop_check("emptypp", 8'h77);

        // Short frame, then clear racing a new length error.
        send_frame(8'h55, 5, 1, 0, 0);
        check("short_len_err", len_err, 1);
        check("short_count", fifo_count, 0);
        done = 1'b1;
        clr_status = 1'b1;
        tick();
        done = 1'b0;
        clr_status = 1'b0;
        check("clr_vs_set", len_err, 1);
        clr();
        check("clr_after", len_err, 0);

        // rx_en low mid-frame discards the partial frame and ignores done.
        send_frame(8'h0F, 4, 0, 0, 0);
        rx_en = 1'b0;
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        check("rxen_len_err", len_err, 0);
        check("rxen_count", fifo_count, 0);
        rx_en = 1'b1;
        send_frame(8'h5A, 8, 1, 0, 0);
        check("rxen_len_err2", len_err, 0);
        pop_check("rxen", 8'h5A);

        // active_rx falling mid-frame discards silently.
        send_frame(8'h07, 3, 0, 0, 0);
        active_rx = 1'b0;
        tick();
        send_frame(8'hC3, 8, 1, 0, 0);
        check("afall_len_err", len_err, 0);
        pop_check("afall", 8'hC3);

        // Idle timeout with one stored frame, then with an empty FIFO.
        send_frame(8'h11, 8, 1, 0, 0);
        d0 = cyc;
        p0 = pulse_cnt;
        repeat (300) tick();
        check("to_pulses", pulse_cnt - p0, EXP_PULSES);
`ifdef UART_RX_IDLE_TIMEOUT_EN
        check("to_pulse_cycle", last_pulse_cyc, d0 + TIMEOUT - 1);
`endif
        pop_check("to", 8'h11);
        p0 = pulse_cnt;
        repeat (300) tick();
        check("to_empty_pulses", pulse_cnt - p0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
